// File: rtl/sync_ram_pkg.sv
// Shared types, constants and helpers for the sync_ram memory primitive.
package sync_ram_pkg;

  // Controller states: clearing the array after reset, then serving requests.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Same-address read-during-write selection.
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Byte-lane merge: take the new byte when its enable is set, else keep the old one.
  function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                          input logic [7:0] new_b,
                                          input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/sync_ram_rsp_pipe.sv
// Read-response delay line: STAGES-deep shift of valid, data and error flag.
module sync_ram_rsp_pipe #(
  parameter int WORD_SIZE = 32,
  parameter int STAGES    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vld,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_err,
  output logic                 o_vld,
  output logic [WORD_SIZE-1:0] o_data,
  output logic                 o_err
);

  logic                 r_vld_p  [STAGES];
  logic [WORD_SIZE-1:0] r_data_p [STAGES];
  logic                 r_err_p  [STAGES];

  // Shift the response forward one stage per clock; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_vld_p[s]  <= 1'b0;
        r_data_p[s] <= '0;
        r_err_p[s]  <= 1'b0;
      end
    end else begin
      r_vld_p[0]  <= i_vld;
      r_data_p[0] <= i_data;
      r_err_p[0]  <= i_err;
      for (int s = 1; s < STAGES; s++) begin
        r_vld_p[s]  <= r_vld_p[s-1];
        r_data_p[s] <= r_data_p[s-1];
        r_err_p[s]  <= r_err_p[s-1];
      end
    end
  end

  assign o_vld  = r_vld_p[STAGES-1];
  assign o_data = r_data_p[STAGES-1];
  assign o_err  = r_err_p[STAGES-1];

endmodule

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with valid/ready requests, byte enables,
// 1- or 2-cycle read latency and a self-clearing sweep after reset.
module sync_ram
  import sync_ram_pkg::*;
#(
  parameter int ADDR_SIZE    = 10,
  parameter int WORD_SIZE    = 32,
  parameter int MEMORY_SIZE  = 1024,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [ADDR_SIZE-1:0]   req_addr,
  input  logic [WORD_SIZE-1:0]   req_wdata,
  input  logic [WORD_SIZE/8-1:0] req_be,
  output logic                   rsp_valid,
  output logic [WORD_SIZE-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic                   wr_err,
  output logic                   init_done
);

  localparam int BYTES = WORD_SIZE / 8;
  localparam int IDX_W = $clog2(MEMORY_SIZE);

  // Parameter sanity; RDW_MODE only selects behaviour that is identical on a
  // single port (a write always commits before the next accepted read), so it
  // is validated here and otherwise reserved for the dual-port variant.
  if (WORD_SIZE % 8 != 0) begin : g_bad_word
    $error("sync_ram: WORD_SIZE must be a multiple of 8");
  end
  if (MEMORY_SIZE < 2 || MEMORY_SIZE > (1 << ADDR_SIZE)) begin : g_bad_size
    $error("sync_ram: MEMORY_SIZE must be in 2..2^ADDR_SIZE");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("sync_ram: READ_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
    $error("sync_ram: RDW_MODE must be 0 or 1");
  end

  state_t               r_state;
  logic [IDX_W-1:0]     r_cnt;
  logic                 r_wr_err;
  logic [WORD_SIZE-1:0] r_mem [MEMORY_SIZE];

  logic                 w_accept;
  logic                 w_in_range;
  logic                 w_we;
  logic [IDX_W-1:0]     w_waddr;
  logic [WORD_SIZE-1:0] w_wdata;
  logic [BYTES-1:0]     w_wbe;
  logic                 w_rd_fire;
  logic [WORD_SIZE-1:0] w_rd_data;
  logic                 w_rd_err;

  assign w_accept   = req_valid && (r_state == ST_READY);
  // Extra top bit so MEMORY_SIZE == 2^ADDR_SIZE does not wrap to zero.
  assign w_in_range = {1'b0, req_addr} < (ADDR_SIZE+1)'(MEMORY_SIZE);

  // Single write port shared by the clear sweep and in-range request writes.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_cnt;
    w_wdata = '0;
    w_wbe   = '1;
    if (!rst) begin
      if (r_state == ST_INIT) begin
        w_we = 1'b1;
      end else if (w_accept && req_wr && w_in_range) begin
        w_we    = 1'b1;
        w_waddr = req_addr[IDX_W-1:0];
        w_wdata = req_wdata;
        w_wbe   = req_be;
      end
    end
  end

  // Storage update, one byte lane at a time.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < BYTES; b++) begin
        r_mem[w_waddr][b*8 +: 8] <= be_merge(r_mem[w_waddr][b*8 +: 8],
                                             w_wdata[b*8 +: 8], w_wbe[b]);
      end
    end
  end

  // Clear-sweep controller and out-of-range write flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_INIT;
      r_cnt    <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_accept && req_wr && !w_in_range;
      if (r_state == ST_INIT) begin
        if (r_cnt == IDX_W'(MEMORY_SIZE - 1)) begin
          r_state <= ST_READY;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Read sampled on the accepting edge; out-of-range reads return zero with error.
  assign w_rd_fire = w_accept && !req_wr;
  assign w_rd_data = w_in_range ? r_mem[req_addr[IDX_W-1:0]] : '0;
  assign w_rd_err  = !w_in_range;

  sync_ram_rsp_pipe #(
    .WORD_SIZE (WORD_SIZE),
    .STAGES    (READ_LATENCY)
  ) u_rsp_pipe (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (w_rd_fire),
    .i_data (w_rd_data),
    .i_err  (w_rd_err),
    .o_vld  (rsp_valid),
    .o_data (rsp_rdata),
    .o_err  (rsp_err)
  );

  assign req_ready = (r_state == ST_READY);
  assign init_done = (r_state == ST_READY);
  assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_sync_ram.sv
// Scoreboard bench for sync_ram: instance 0 is 1024 words / latency 1 /
// read-first, instance 1 is 1000 words / latency 2 / write-first.
module tb_sync_ram;

  localparam int AW = 10;
  localparam int WW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_s  [2];
  logic          rv     [2];
  logic          rr     [2];
  logic          rw     [2];
  logic [AW-1:0] ra     [2];
  logic [WW-1:0] rwd    [2];
  logic [BW-1:0] rbe    [2];
  logic          vo     [2];
  logic [WW-1:0] rdat   [2];
  logic          rerr   [2];
  logic          werr   [2];
  logic          idone  [2];

  sync_ram #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .MEMORY_SIZE(1024),
             .READ_LATENCY(1), .RDW_MODE(0)) u_a (
    .clk(clk), .rst(rst_s[0]), .req_valid(rv[0]), .req_ready(rr[0]),
    .req_wr(rw[0]), .req_addr(ra[0]), .req_wdata(rwd[0]), .req_be(rbe[0]),
    .rsp_valid(vo[0]), .rsp_rdata(rdat[0]), .rsp_err(rerr[0]),
    .wr_err(werr[0]), .init_done(idone[0]));

  sync_ram #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .MEMORY_SIZE(1000),
             .READ_LATENCY(2), .RDW_MODE(1)) u_b (
    .clk(clk), .rst(rst_s[1]), .req_valid(rv[1]), .req_ready(rr[1]),
    .req_wr(rw[1]), .req_addr(ra[1]), .req_wdata(rwd[1]), .req_be(rbe[1]),
    .rsp_valid(vo[1]), .rsp_rdata(rdat[1]), .rsp_err(rerr[1]),
    .wr_err(werr[1]), .init_done(idone[1]));

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          at_edge;
  } exp_t;

  exp_t        expq [2][$];
  int          wq   [2][$];
  logic [31:0] mdl  [2][1024];

  int ecnt   = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic int msz(input int k);
    return (k == 0) ? 1024 : 1000;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d actual=0x%08h required=0x%08h t=%0t", nm, k, act, req, $time);
    end
  endtask

  task automatic model_clear(input int k);
    for (int a = 0; a < 1024; a++) mdl[k][a] = 32'h0;
  endtask

  // One request slot: decide acceptance from req_ready, update the model, then drive.
  task automatic drive(input int k, input logic v, input logic w, input int a,
                       input logic [31:0] d, input logic [3:0] be);
    logic [31:0] m;
    exp_t e;
    @(negedge clk);
    if (v && rr[k] === 1'b1 && !rst_s[k]) begin
      if (w) begin
        if (a < msz(k)) begin
          for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
          mdl[k][a] = (mdl[k][a] & ~m) | (d & m);
        end else begin
          wq[k].push_back(ecnt + 1);
        end
      end else begin
        e.data    = (a < msz(k)) ? mdl[k][a] : 32'h0;
        e.err     = (a >= msz(k));
        e.at_edge = ecnt + 1 + lat(k) - 1;
        expq[k].push_back(e);
      end
    end
    rv[k]  = v;
    rw[k]  = w;
    ra[k]  = AW'(a);
    rwd[k] = d;
    rbe[k] = be;
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) drive(k, 1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  // Assert reset, check reset values, release and time the clear sweep.
  task automatic do_reset(input int k, input int hold);
    int e1;
    int n;
    @(negedge clk);
    rst_s[k] = 1'b1;
    rv[k]    = 1'b0;
    while (expq[k].size() > 0 && expq[k][expq[k].size()-1].at_edge >= ecnt + 1)
      void'(expq[k].pop_back());
    while (wq[k].size() > 0 && wq[k][wq[k].size()-1] >= ecnt + 1)
      void'(wq[k].pop_back());
    model_clear(k);
    repeat (hold) @(negedge clk);
    chk("rst_req_ready", k, 32'(rr[k]), 32'h0);
    chk("rst_init_done", k, 32'(idone[k]), 32'h0);
    chk("rst_rsp_valid", k, 32'(vo[k]), 32'h0);
    chk("rst_rsp_rdata", k, rdat[k], 32'h0);
    chk("rst_rsp_err", k, 32'(rerr[k]), 32'h0);
    chk("rst_wr_err", k, 32'(werr[k]), 32'h0);
    rst_s[k] = 1'b0;
    e1 = ecnt + 1;
    n  = 0;
    while (rr[k] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (rr[k] !== 1'b1) begin
      chk("ready_timeout", k, 32'(rr[k]), 32'h1);
    end else begin
      chk("ready_delay", k, 32'(ecnt - e1 + 1), 32'(msz(k)));
      chk("init_done_up", k, 32'(idone[k]), 32'h1);
    end
  endtask

  task automatic run_tests(input int k);
    // Cleared contents after the sweep.
    drive(k, 1'b1, 1'b0, 'h000, 32'h0, 4'h0);
    drive(k, 1'b1, 1'b0, 'h200, 32'h0, 4'h0);
    drive(k, 1'b1, 1'b0, 'h3FF, 32'h0, 4'h0);
    idle(k, 3);
    // Byte-enable merge.
    drive(k, 1'b1, 1'b1, 'h010, 32'hDEADBEEF, 4'b1111);
    drive(k, 1'b1, 1'b1, 'h010, 32'h000000AA, 4'b0001);
    drive(k, 1'b1, 1'b0, 'h010, 32'h0, 4'h0);
    drive(k, 1'b1, 1'b1, 'h010, 32'h55555555, 4'b0000);
    drive(k, 1'b1, 1'b0, 'h010, 32'h0, 4'h0);
    idle(k, 3);
    // Back-to-back stream with req_ready held high.
    drive(k, 1'b1, 1'b1, 5, 32'hA0A0A0A0, 4'hF);
    chk("b2b_ready", k, 32'(rr[k]), 32'h1);
    drive(k, 1'b1, 1'b0, 5, 32'h0, 4'h0);
    chk("b2b_ready", k, 32'(rr[k]), 32'h1);
    drive(k, 1'b1, 1'b1, 5, 32'hB0B0B0B0, 4'hF);
    chk("b2b_ready", k, 32'(rr[k]), 32'h1);
    drive(k, 1'b1, 1'b0, 5, 32'h0, 4'h0);
    chk("b2b_ready", k, 32'(rr[k]), 32'h1);
    idle(k, 3);
    // Address 1010: out of range for the 1000-word instance.
    drive(k, 1'b1, 1'b1, 1010, 32'hCAFEF00D, 4'hF);
    drive(k, 1'b1, 1'b0, 1010, 32'h0, 4'h0);
    drive(k, 1'b1, 1'b0, 10, 32'h0, 4'h0);
    drive(k, 1'b1, 1'b0, 999, 32'h0, 4'h0);
    idle(k, 3);
    // Randomised traffic, biased toward a few hot words to get read-after-write hits.
    for (int i = 0; i < 400; i++) begin
      int a;
      a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1023));
      drive(k, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom));
    end
    idle(k, 4);
    // Reset the cycle after a read is accepted.
    drive(k, 1'b1, 1'b1, 'h010, 32'h12345678, 4'hF);
    drive(k, 1'b1, 1'b0, 'h010, 32'h0, 4'h0);
    do_reset(k, 2);
    drive(k, 1'b1, 1'b0, 'h010, 32'h0, 4'h0);
    idle(k, 4);
    chk("drain_rsp", k, 32'(expq[k].size()), 32'h0);
    chk("drain_wr_err", k, 32'(wq[k].size()), 32'h0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1;
      rv[k]    = 1'b0;
      rw[k]    = 1'b0;
      ra[k]    = '0;
      rwd[k]   = '0;
      rbe[k]   = '0;
      model_clear(k);
    end
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          for (int k = 0; k < 2; k++) begin
            exp_t e;
            logic hit;
            if (vo[k] === 1'b1) begin
              if (expq[k].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp dut%0d actual rsp_valid=1 required rsp_valid=0 t=%0t", k, $time);
              end else begin
                e = expq[k].pop_front();
                chk("rsp_edge", k, 32'(ecnt), 32'(e.at_edge));
                chk("rsp_rdata", k, rdat[k], e.data);
                chk("rsp_err", k, 32'(rerr[k]), 32'(e.err));
              end
            end else if (expq[k].size() > 0 && expq[k][0].at_edge <= ecnt) begin
              e = expq[k].pop_front();
              chk("rsp_missing", k, 32'(vo[k]), 32'h1);
            end
            hit = (wq[k].size() > 0 && wq[k][0] == ecnt);
            if (werr[k] === 1'b1 || hit) begin
              chk("wr_err", k, 32'(werr[k]), 32'(hit));
              if (hit) void'(wq[k].pop_front());
            end
          end
        end
      end
      begin : stimulus
        for (int k = 0; k < 2; k++) begin
          do_reset(k, 3);
          run_tests(k);
        end
        idle(0, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join
  end

endmodule
